// File: rtl/uart_receive_frame.sv
// uart_receive_frame
//   UART receiver with configurable frame format (DATA_BITS, PARITY, STOP_BITS),
//   a 2-flop input synchroniser, 3-sample majority voting, false-start rejection
//   and a show-ahead output FIFO behind a ready/valid handshake.
//
// Ports
//   i_clock         clock
//   i_reset         synchronous, active-high reset
//   i_rx            serial line, asynchronous, idle high
//   o_data          payload of head FIFO entry
//   o_data_valid    FIFO non-empty
//   i_data_ready    consumer accepts head entry when high with o_data_valid
//   o_parity_error  head entry parity mismatch (0 when PARITY = 0)
//   o_frame_error   head entry saw a 0 on some stop-bit sample
//   o_break         head entry is all-zero data/parity with a frame error
//   o_overrun       one-cycle pulse when a completed frame is dropped
module uart_receive_frame #(
  // Defaults exist only so the block elaborates standalone; every
  // instantiation is expected to set the clock and baud rate explicitly.
  parameter int CLOCK_FREQUENCY = 1_600_000,
  parameter int BAUD_RATE       = 100_000,
  parameter int DATA_BITS       = 8,
  parameter int PARITY          = 0,   // 0 none, 1 odd, 2 even
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic                 o_parity_error,
  output logic                 o_frame_error,
  output logic                 o_break,
  output logic                 o_overrun
);
  localparam int N_CLOCKS = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int M        = N_CLOCKS / 2;
  localparam int CW       = $clog2(N_CLOCKS);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = DATA_BITS + 3;

  localparam logic [CW-1:0] C_LAST  = CW'(N_CLOCKS - 1);
  localparam logic [CW-1:0] C_SAMP0 = CW'(M - 1);
  localparam logic [CW-1:0] C_SAMP1 = CW'(M);
  localparam logic [CW-1:0] C_MPT   = CW'(M + 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [3:0]    B_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    B_SLAST = 4'(STOP_BITS - 1);
  localparam logic [3:0]    B_ONE   = 4'd1;
  localparam logic [AW:0]   P_ONE   = (AW+1)'(1);
  localparam logic          PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  logic                 r_sync1, r_sync2;
  logic [CW-1:0]        r_count;
  logic [3:0]           r_bitcnt;
  logic                 r_samp0, r_samp1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit, r_par_err, r_frm_err;
  logic                 r_push;
  logic [EW-1:0]        r_entry;

  logic                 w_rx, w_maj, w_mpt, w_frm_final, w_brk;

  assign w_rx  = r_sync2;
  // 2-of-3 vote: the third sample is the live value at the resolve count.
  assign w_maj = (r_samp0 & r_samp1) | (r_samp0 & w_rx) | (r_samp1 & w_rx);
  assign w_mpt = (r_count == C_MPT);
  assign w_frm_final = r_frm_err | ~w_maj;
  assign w_brk = (r_shift == '0) && ((PARITY == 0) || !r_par_bit) && w_frm_final;

  // The IDLE cycle that first sees rx_s low counts as sample count 0, so the
  // counter value equals the cycle offset from start detection within a bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_bitcnt  <= '0;
      r_samp0   <= 1'b1;
      r_samp1   <= 1'b1;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_push    <= 1'b0;
      r_entry   <= '0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_push  <= 1'b0;
      if (r_count == C_SAMP0) r_samp0 <= w_rx;
      if (r_count == C_SAMP1) r_samp1 <= w_rx;
      if (r_state == S_IDLE) r_count <= w_rx ? '0 : C_ONE;
      else                   r_count <= (r_count == C_LAST) ? '0 : r_count + C_ONE;
      case (r_state)
        S_IDLE: if (!w_rx) begin
          r_state   <= S_START;
          r_par_err <= 1'b0;
          r_frm_err <= 1'b0;
          r_par_bit <= 1'b0;
        end
        S_START: if (w_mpt) begin
          if (w_maj) begin
            r_state <= S_IDLE;    // glitch: not a real start bit
            r_count <= '0;
          end else begin
            r_state  <= S_DATA;
            r_bitcnt <= '0;
          end
        end
        S_DATA: if (w_mpt) begin
          r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (r_bitcnt == B_DLAST) begin
            r_bitcnt <= '0;
            r_state  <= (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            r_bitcnt <= r_bitcnt + B_ONE;
          end
        end
        S_PARITY: if (w_mpt) begin
          r_par_bit <= w_maj;
          r_par_err <= w_maj ^ (^r_shift) ^ PAR_ODD;
          r_state   <= S_STOP;
        end
        S_STOP: if (w_mpt) begin
          if (r_bitcnt == B_SLAST) begin
            // Leave at mid-bit so a back-to-back start edge is never missed.
            r_state <= S_IDLE;
            r_count <= '0;
            r_push  <= 1'b1;
            r_entry <= {w_brk, w_frm_final, r_par_err, r_shift};
          end else begin
            r_frm_err <= w_frm_final;
            r_bitcnt  <= r_bitcnt + B_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: extra pointer MSB distinguishes full from empty.
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic          w_empty, w_full, w_pop, w_push;
  logic [EW-1:0] w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && i_data_ready;
  assign w_push  = r_push && (!w_full || w_pop);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_entry;
  end

  assign w_head         = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_data         = w_head[DATA_BITS-1:0];
  assign o_parity_error = w_head[DATA_BITS];
  assign o_frame_error  = w_head[DATA_BITS+1];
  assign o_break        = w_head[DATA_BITS+2];
  assign o_data_valid   = !w_empty;
  assign o_overrun      = r_push && w_full && !w_pop;
endmodule

// File: doc/uart_receive_frame.md
# uart_receive_frame

Parametrised UART receiver that succeeds the fixed 8N1 simulation receiver in the UART transactor. It adds:

- a configurable frame format: data bits, parity, stop bits;
- input synchronisation, majority-vote sampling and false-start rejection;
- per-frame error reporting;
- an output FIFO behind a ready/valid interface.

It sits between the serial line from the DUT and the transactor's byte consumer.

## Interface
- CLOCK_FREQUENCY, no default, i_clock frequency in Hz
- BAUD_RATE, no default, line rate; N_CLOCKS = CLOCK_FREQUENCY / BAUD_RATE, integer division, must be ≥ 8
- DATA_BITS, 8, payload bits per frame, 5..9
- PARITY, 0, 0 none / 1 odd / 2 even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, output FIFO entries, power of two, ≥ 2
- i_clock  in  1  clock
- i_reset  in  1  reset i_reset, synchronous, active-high; clock i_clock
- i_rx  in  1  serial input, asynchronous, idle high
- o_data  out  DATA_BITS  payload of head FIFO entry, LSB first on the line
- o_data_valid  out  1  FIFO non-empty
- i_data_ready  in  1  consumer accepts head entry when high together with o_data_valid
- o_parity_error  out  1  head entry parity mismatch; always 0 when PARITY=0
- o_frame_error  out  1  head entry had at least one stop-bit sample of 0
- o_break  out  1  head entry: all data bits 0, parity sample 0 (if present) and frame error
- o_overrun  out  1  one-cycle pulse when a completed frame is dropped

## Operation
- Synchroniser: 2 flops on i_rx, both reset to 1. The FSM sees the synchronised value rx_s only.
- Counters:
  - sample counter, $clog2(N_CLOCKS) bits, counts 0..N_CLOCKS-1 and wraps to 0;
  - bit counter, 4 bits.
- Majority sampling: rx_s is taken at counter values M-1, M and M+1, with M = N_CLOCKS/2. The bit value is the 2-of-3 majority, resolved at count M+1.
- FSM states and transitions:
  - IDLE: when rx_s == 0, the counter loads 0 and the FSM enters START.
  - START: at the majority point:
    - majority 1 → IDLE (glitch rejected, nothing pushed);
    - majority 0 → DATA with the bit counter at 0.
  - DATA: majority is shifted in LSB-first once per bit, at the majority point.
    - After DATA_BITS bits the FSM goes to PARITY if PARITY≠0, else to STOP.
  - PARITY: the majority is checked.
    - Expected parity bit = XOR of the data bits, inverted for odd parity.
    - A mismatch sets the parity error.
  - STOP: each stop bit is sampled at its majority point; any 0 sets the frame error.
    - At the majority point of the last stop bit the frame completes and the FSM returns to IDLE immediately.
    - There is no wait for the end of the bit, so resync on back-to-back frames stays within half a bit.
- Completion: the frame pushes {break, frame_err, parity_err, data} into the FIFO on the cycle after the final stop sample.
- FIFO behaviour:
  - Show-ahead: head outputs are valid combinationally from storage while o_data_valid = 1.
  - Pop on o_data_valid && i_data_ready.
  - When full, a push is accepted only if a pop happens in the same cycle. Otherwise the frame is dropped, o_overrun pulses 1 cycle and FIFO contents are unchanged.
  - Push into an empty FIFO: o_data_valid rises the following cycle.
  - Pointers are one bit wider than log2(FIFO_DEPTH). Full and empty come from pointer compare, and pointers wrap naturally.
- Reset values, effective the cycle after i_reset is sampled high:
  - o_data_valid = 0, o_overrun = 0, FIFO empty, FSM IDLE, counters 0, synchroniser 1;
  - o_data, o_parity_error, o_frame_error and o_break read 0 while empty.
- Reset mid-frame abandons the frame; no push occurs.

## Timing
- The falling edge on i_rx reaches rx_s 2 cycles later. IDLE → START is detected in that cycle.
- Frame start to push, measured from the IDLE→START cycle: push is 1 cycle after the final stop-bit majority point.
  - The final stop-bit majority point is at offset (1+DATA_BITS+P+STOP_BITS−1)·N_CLOCKS + M+1 cycles, where P = 1 if PARITY≠0, else 0.
- o_data_valid rises 1 cycle after push into an empty FIFO. Pop-to-next-head is 0 cycles, since the head updates on the pop edge.
- o_overrun coincides with the cycle a push would have occurred.
- Back-to-back frames with no idle time between them must be received without loss at ±2% baud error.

## Test plan
Bench uses N_CLOCKS = 16 (CLOCK_FREQUENCY = 1_600_000, BAUD_RATE = 100_000).

- 8N1, send 0xA5, i_data_ready = 1:
  - exactly one o_data_valid cycle with o_data = 0xA5 and all error flags 0;
  - the push lands at cycle 2 + 9·16 + 9 + 1 after the start edge on i_rx.
- 8E1 (PARITY=2), send 0x03 with parity bit 1 → o_data = 0x03, o_parity_error = 1. Send 0x03 with parity bit 0 → o_parity_error = 0.
- 8N1, send 0x5A with stop bit 0 → o_frame_error = 1, o_break = 0. Send 0x00 with stop bit 0 → o_break = 1, o_frame_error = 1.
- Glitch: drive a 4-cycle low pulse on idle i_rx → no push, FSM back in IDLE. A following valid frame 0x3C is received correctly.
- Overrun, FIFO_DEPTH = 4, i_data_ready = 0, five frames 0x01..0x05:
  - o_overrun pulses once, on frame 5;
  - draining then yields 0x01..0x04 in order, after which o_data_valid = 0.
- 7O2 (DATA_BITS=7, PARITY=1, STOP_BITS=2), back-to-back frames 0x7F and 0x00 at +2% baud error → both received with no errors. Assert i_reset mid-frame in a third frame → no push, and o_data_valid = 0 after reset.
